// File: rtl/gray_sweep_pkg.sv
// Shared types and helpers for the Gray-code sweep controller.
// popcount is only used when GRAY_SWEEP_CHECK_EN is defined.
package gray_sweep_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Callers zero-extend into MAX_W bits and truncate the result back to their width.
  function automatic logic [MAX_W-1:0] bin2gray_f(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) n += {31'b0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/gray_sweep_bin2gray.sv
// Combinational binary-to-Gray converter.
module gray_sweep_bin2gray
  import gray_sweep_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = WIDTH'(bin2gray_f(MAX_W'(bin)));

endmodule

// File: rtl/gray_sweep_ctrl.sv
// Sweeps a programmable range of binary codes and streams them with their Gray codes.
// Optional GRAY_SWEEP_CHECK_EN adds a sticky gray_err flag for non-unit-distance transfers.
module gray_sweep_ctrl
  import gray_sweep_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] cfg_first,
  input  logic [WIDTH-1:0] cfg_last,
  input  logic             cfg_dir,
  input  logic             cfg_loop,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
`ifdef GRAY_SWEEP_CHECK_EN
  output logic             gray_err,
`endif
  output logic             done
);

  state_t           state, state_n;
  logic [WIDTH-1:0] bin_n;
  logic [WIDTH-1:0] first_q, last_q;
  logic             dir_q, loop_q;
  logic             load;

  // Abort outranks both start and transfer; cfg is only captured on load.
  always_comb begin
    state_n = state;
    bin_n   = bin_out;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n = RUN;
          bin_n   = cfg_first;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (out_ready) begin
          if (bin_out == last_q) begin
            if (loop_q) bin_n = first_q;
            else        state_n = DONE;
          end else begin
            bin_n = dir_q ? bin_out - WIDTH'(1) : bin_out + WIDTH'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bin_out <= '0;
      first_q <= '0;
      last_q  <= '0;
      dir_q   <= 1'b0;
      loop_q  <= 1'b0;
    end else begin
      state   <= state_n;
      bin_out <= bin_n;
      if (load) begin
        first_q <= cfg_first;
        last_q  <= cfg_last;
        dir_q   <= cfg_dir;
        loop_q  <= cfg_loop;
      end
    end
  end

  assign out_valid = (state == RUN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  gray_sweep_bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
    .bin  (bin_out),
    .gray (gray_out)
  );

`ifdef GRAY_SWEEP_CHECK_EN
  logic [WIDTH-1:0] prev_gray;
  logic             have_prev;
  logic             xfer;

  assign xfer = (state == RUN) && !abort && out_ready;

  // The word after a loop restart has no valid predecessor, so the comparison chain restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_err  <= 1'b0;
      have_prev <= 1'b0;
      prev_gray <= '0;
    end else if (load) begin
      gray_err  <= 1'b0;
      have_prev <= 1'b0;
    end else if (xfer) begin
      if (have_prev && popcount(MAX_W'(prev_gray ^ gray_out)) != 1) gray_err <= 1'b1;
      prev_gray <= gray_out;
      have_prev <= !(loop_q && bin_out == last_q);
    end
  end
`endif

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// Directed self-checking bench for gray_sweep_ctrl (WIDTH=4).
// Define GRAY_SWEEP_CHECK_EN to also exercise the gray_err checker.
module tb_gray_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] cfg_first = '0;
  logic [3:0] cfg_last = '0;
  logic       cfg_dir = 1'b0;
  logic       cfg_loop = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] bin_out, gray_out;
  logic       out_valid, busy, done;
`ifdef GRAY_SWEEP_CHECK_EN
  logic       gray_err;
`endif

  int checkCount = 0;
  int errorCount = 0;

  logic [3:0] expUp [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
  logic [3:0] expDnGray [7] = '{4'h2, 4'h3, 4'h1, 4'h0, 4'h8, 4'h9, 4'hB};
  logic [3:0] expDnBin  [7] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd15, 4'd14, 4'd13};
  logic [3:0] expWrap   [4] = '{4'h9, 4'h8, 4'h0, 4'h1};
  logic [3:0] readyPat = 4'b1001;

  gray_sweep_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cfg_first (cfg_first),
    .cfg_last  (cfg_last),
    .cfg_dir   (cfg_dir),
    .cfg_loop  (cfg_loop),
    .bin_out   (bin_out),
    .gray_out  (gray_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
`ifdef GRAY_SWEEP_CHECK_EN
    .gray_err  (gray_err),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] f, input logic [3:0] l, input logic d, input logic lp);
    cfg_first = f;
    cfg_last  = l;
    cfg_dir   = d;
    cfg_loop  = lp;
    start     = 1'b1;
    tick;
    start     = 1'b0;
  endtask

  initial begin
    logic [3:0] held;
    int         n;
    bit         seenDone;

    tick;
    tick;
    checkOutput("rst_bin", bin_out, 0);
    checkOutput("rst_gray", gray_out, 0);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    rst = 1'b0;
    tick;

    $display("[TB] full up sweep 0..15");
    out_ready = 1'b1;
    applyStimulus(4'd0, 4'd15, 1'b0, 1'b0);
    checkOutput("t1_first_valid", out_valid, 1);
    for (int i = 0; i < 16; i++) begin
      checkOutput("t1_gray", gray_out, expUp[i]);
      checkOutput("t1_bin", bin_out, i);
      tick;
    end
    checkOutput("t1_done", done, 1);
    checkOutput("t1_busy_in_done", busy, 1);
    checkOutput("t1_valid_in_done", out_valid, 0);
`ifdef GRAY_SWEEP_CHECK_EN
    checkOutput("t1_gray_err", gray_err, 0);
`endif
    tick;
    checkOutput("t1_done_pulse", done, 0);
    checkOutput("t1_busy_idle", busy, 0);
    checkOutput("t1_bin_hold", bin_out, 15);

    $display("[TB] up sweep with backpressure");
    applyStimulus(4'd0, 4'd15, 1'b0, 1'b0);
    n = 0;
    seenDone = 1'b0;
    for (int c = 0; c < 100 && !seenDone; c++) begin
      out_ready = readyPat[c % 4];
      if (out_valid && out_ready) begin
        if (n < 16) checkOutput("t2_gray", gray_out, expUp[n]);
        n++;
        tick;
      end else begin
        held = gray_out;
        tick;
        if (!done) checkOutput("t2_hold", gray_out, held);
      end
      if (done) seenDone = 1'b1;
    end
    checkOutput("t2_count", n, 16);
    checkOutput("t2_done_seen", seenDone, 1);
    out_ready = 1'b1;
    tick;

    $display("[TB] down sweep 3..13 with start/cfg changes while busy");
    applyStimulus(4'd3, 4'd13, 1'b1, 1'b0);
    cfg_first = 4'd0;
    cfg_last  = 4'd1;
    cfg_dir   = 1'b0;
    cfg_loop  = 1'b1;
    start     = 1'b1;
    for (int i = 0; i < 7; i++) begin
      checkOutput("t3_gray", gray_out, expDnGray[i]);
      checkOutput("t3_bin", bin_out, expDnBin[i]);
      tick;
    end
    start = 1'b0;
    checkOutput("t3_done", done, 1);
    tick;
    checkOutput("t3_idle", busy, 0);

    $display("[TB] up sweep wrapping 14..1");
    applyStimulus(4'd14, 4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t4_gray", gray_out, expWrap[i]);
      tick;
    end
    checkOutput("t4_done", done, 1);
    tick;

    $display("[TB] looping 5..6 then abort");
    applyStimulus(4'd5, 4'd6, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checkOutput("t5_gray", gray_out, (i % 2 == 0) ? 32'h7 : 32'h5);
      tick;
    end
    abort = 1'b1;
    start = 1'b1;
    tick;
    checkOutput("t5_abort_valid", out_valid, 0);
    checkOutput("t5_abort_busy", busy, 0);
    checkOutput("t5_abort_done", done, 0);
    checkOutput("t5_abort_bin", bin_out, 5);
    tick;
    checkOutput("t5_start_ignored", busy, 0);
    abort = 1'b0;
    start = 1'b0;
    tick;
    checkOutput("t5_no_done", done, 0);

    $display("[TB] single word 9..9");
    applyStimulus(4'd9, 4'd9, 1'b0, 1'b0);
    checkOutput("t6_bin", bin_out, 9);
    checkOutput("t6_gray", gray_out, 4'hD);
    checkOutput("t6_valid", out_valid, 1);
    tick;
    checkOutput("t6_done", done, 1);
    checkOutput("t6_valid_off", out_valid, 0);
    tick;
    checkOutput("t6_done_off", done, 0);
    checkOutput("t6_bin_hold", bin_out, 9);

    $display("[TB] reset mid-sweep");
    applyStimulus(4'd0, 4'd15, 1'b0, 1'b0);
    repeat (5) tick;
    checkOutput("t7_pre_bin", bin_out, 5);
    rst = 1'b1;
    tick;
    checkOutput("t7_bin", bin_out, 0);
    checkOutput("t7_gray", gray_out, 0);
    checkOutput("t7_valid", out_valid, 0);
    checkOutput("t7_busy", busy, 0);
    checkOutput("t7_done", done, 0);
    rst = 1'b0;
    tick;
    checkOutput("t7_no_done", done, 0);

`ifdef GRAY_SWEEP_CHECK_EN
    $display("[TB] gray_err on forced jump");
    applyStimulus(4'd0, 4'd15, 1'b0, 1'b0);
    repeat (3) tick;
    checkOutput("t8_pre_err", gray_err, 0);
    force dut.bin_out = 4'd4;
    tick;
    release dut.bin_out;
    checkOutput("t8_err_set", gray_err, 1);
    repeat (3) tick;
    checkOutput("t8_err_sticky", gray_err, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checkOutput("t8_err_after_abort", gray_err, 1);
    applyStimulus(4'd0, 4'd15, 1'b0, 1'b0);
    checkOutput("t8_err_cleared", gray_err, 0);
    repeat (4) tick;
    checkOutput("t8_err_clean_run", gray_err, 0);
    abort = 1'b1;
    tick;
    abort = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
